// File: rtl/s_axis_word_unpacker_if.sv
// Handshake bundle for s_axis_word_unpacker: AXIS beat side,
// word stream side and the frame/error status outputs.
interface s_axis_word_unpacker_if #(
    parameter int C_S_TDATA_WDT    = 32,
    parameter int C_S_TKEEP_WDT    = 4,
    parameter int C_ARITH_WORD_LEN = 32
);
    logic [C_S_TDATA_WDT-1:0]    s_axis_tdata;
    logic [C_S_TKEEP_WDT-1:0]    s_axis_tkeep;
    logic                        s_axis_tlast;
    logic                        s_axis_tvalid;
    logic                        s_axis_tready;
    logic [C_ARITH_WORD_LEN-1:0] m_word_data;
    logic                        m_word_last;
    logic                        m_word_valid;
    logic                        m_word_ready;
    logic                        frame_done;
    logic [15:0]                 err_cnt;

    modport slave (
        input  s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid,
        input  m_word_ready,
        output s_axis_tready,
        output m_word_data, m_word_last, m_word_valid,
        output frame_done, err_cnt
    );

    modport master (
        output s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid,
        output m_word_ready,
        input  s_axis_tready,
        input  m_word_data, m_word_last, m_word_valid,
        input  frame_done, err_cnt
    );
endinterface

// File: rtl/s_axis_word_unpacker.sv
// AXIS ingress unpacker: splits 2x16-bit beats into widened words.
// Optional malformed-beat counter enabled by S_AXIS_UNPACK_ERR_CNT_EN.
package arith_pckg;
    localparam int C_ARITH_WORD_LEN = 32;
endpackage

module s_axis_word_unpacker
    import arith_pckg::*;
#(
    parameter int C_S_TDATA_WDT       = 32,
    parameter int C_S_TKEEP_WDT       = 4,
    parameter int C_EXT_DATA_WORD_WDT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    s_axis_word_unpacker_if.slave  bus
);
    localparam int EW = C_EXT_DATA_WORD_WDT;
    localparam int HK = C_S_TKEEP_WDT / 2;
    localparam int ZW = C_ARITH_WORD_LEN - EW;

    typedef enum logic [1:0] {EMPTY, W0, W1} state_t;

    state_t                      state;
    logic [C_S_TDATA_WDT-1:0]    buf_data;
    logic                        buf_v1;
    logic                        buf_last;
    logic                        empty_last;
    logic [C_ARITH_WORD_LEN-1:0] data_q;
    logic                        last_q;
    logic                        valid_q;

    logic [EW-1:0] word;
    logic          pend;
    logic          pend_final;
    logic          load;
    logic          adv;
    logic          v0;
    logic          v1;
    logic          accept;
    logic          tready;

    // Select the pending word and derive the drain/accept conditions.
    always_comb begin
        pend       = (state != EMPTY);
        pend_final = (state == W1) || (state == W0 && !buf_v1);
        word       = (state == W1) ? buf_data[2*EW-1:EW] : buf_data[EW-1:0];
        load       = !valid_q || bus.m_word_ready;
        adv        = pend && load;
        v0         = &bus.s_axis_tkeep[HK-1:0];
        v1         = &bus.s_axis_tkeep[C_S_TKEEP_WDT-1:HK];
        tready     = !rst && (state == EMPTY || (adv && pend_final));
        accept     = bus.s_axis_tvalid && tready;
    end

    assign bus.s_axis_tready = tready;
    assign bus.m_word_data   = data_q;
    assign bus.m_word_last   = last_q;
    assign bus.m_word_valid  = valid_q;
    assign bus.frame_done    = (valid_q && bus.m_word_ready && last_q)
                             || empty_last;

    // Beat buffer FSM plus the registered word output stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= EMPTY;
            buf_data   <= '0;
            buf_v1     <= 1'b0;
            buf_last   <= 1'b0;
            empty_last <= 1'b0;
            data_q     <= '0;
            last_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            empty_last <= accept && bus.s_axis_tlast && !v0 && !v1;
            if (load) begin
                valid_q <= pend;
                if (pend) begin
                    data_q <= C_ARITH_WORD_LEN'(word) << ZW;
                    last_q <= buf_last && pend_final;
                end else begin
                    last_q <= 1'b0;
                end
            end
            // A new beat can only arrive when the old one is fully drained,
            // so accept simply overrides the drain transition.
            if (accept) begin
                buf_data <= bus.s_axis_tdata;
                buf_v1   <= v1;
                buf_last <= bus.s_axis_tlast;
                if (v0)
                    state <= W0;
                else if (v1)
                    state <= W1;
                else
                    state <= EMPTY;
            end else if (adv) begin
                state <= (state == W0 && buf_v1) ? W1 : EMPTY;
            end
        end
    end

`ifdef S_AXIS_UNPACK_ERR_CNT_EN
    logic [15:0] err_q;
    logic        bad;
    logic [HK-1:0] lo_k;
    logic [HK-1:0] hi_k;

    // Classify the offered beat as malformed.
    always_comb begin
        lo_k = bus.s_axis_tkeep[HK-1:0];
        hi_k = bus.s_axis_tkeep[C_S_TKEEP_WDT-1:HK];
        bad  = ((|lo_k) && !(&lo_k))
            || ((|hi_k) && !(&hi_k))
            || (!(&bus.s_axis_tkeep) && !bus.s_axis_tlast)
            || (!(|bus.s_axis_tkeep) && bus.s_axis_tlast);
    end

    // Saturating count of accepted malformed beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_q <= '0;
        else if (accept && bad && err_q != 16'hFFFF)
            err_q <= err_q + 16'd1;
    end

    assign bus.err_cnt = err_q;
`else
    assign bus.err_cnt = '0;
`endif
endmodule

// File: tb/tb_s_axis_word_unpacker.sv
// Directed bench for s_axis_word_unpacker: vector table plus
// throughput, empty-tlast, backpressure and mid-frame reset sequences.
module tb_s_axis_word_unpacker;
    import arith_pckg::*;
    localparam int WL = C_ARITH_WORD_LEN;
`ifdef S_AXIS_UNPACK_ERR_CNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    s_axis_word_unpacker_if #(.C_ARITH_WORD_LEN(WL)) bus();

    s_axis_word_unpacker dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [WL-1:0] data;
        logic          last;
        int            c;
    } obs_t;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
        int          n;
        logic [31:0] w0;
        logic [31:0] w1;
        logic        l0;
        logic        l1;
        int          fd;
        int          err;
    } vec_t;

    obs_t got[$];
    obs_t exp_q[$];
    int   fd_cnt = 0;
    int   fd_cyc = 0;
    bit   mon_en = 1'b0;
    bit   rand_ready = 1'b0;
    bit   hold_low = 1'b0;
    int   exp_err = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Downstream ready driver.
    initial begin
        bus.m_word_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (hold_low)
                bus.m_word_ready = 1'b0;
            else if (rand_ready)
                bus.m_word_ready = 1'($urandom_range(0, 1));
            else
                bus.m_word_ready = 1'b1;
        end
    end

    // Word monitor: records handshakes, frame_done, and checks hold stability.
    initial begin
        bit            stall;
        logic [WL-1:0] sd;
        logic          sl;
        stall = 1'b0;
        sd    = '0;
        sl    = 1'b0;
        forever begin
            @(negedge clk);
            if (!mon_en || rst) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    tests++;
                    if (!(bus.m_word_valid === 1'b1 && bus.m_word_data === sd
                          && bus.m_word_last === sl)) begin
                        fails++;
                        $display("FAIL hold_stable: got v=%0b d=%0h l=%0b expected v=1 d=%0h l=%0b",
                                 bus.m_word_valid, bus.m_word_data,
                                 bus.m_word_last, sd, sl);
                    end
                end
                if (bus.m_word_valid && bus.m_word_ready)
                    got.push_back('{bus.m_word_data, bus.m_word_last, cyc});
                if (bus.frame_done) begin
                    fd_cnt++;
                    fd_cyc = cyc;
                end
                stall = bus.m_word_valid && !bus.m_word_ready;
                sd    = bus.m_word_data;
                sl    = bus.m_word_last;
            end
        end
    end

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k,
                             input logic l, output int acc);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        acc = 0;
        bus.s_axis_tdata  = d;
        bus.s_axis_tkeep  = k;
        bus.s_axis_tlast  = l;
        bus.s_axis_tvalid = 1'b1;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok  = bus.s_axis_tready;
            acc = cyc;
            @(posedge clk);
            #1;
            n++;
        end
        bus.s_axis_tvalid = 1'b0;
        if (!ok) check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic bit is_bad(input logic [3:0] k, input logic l);
        bit h0, h1;
        h0 = (k[1:0] == 2'b01) || (k[1:0] == 2'b10);
        h1 = (k[3:2] == 2'b01) || (k[3:2] == 2'b10);
        return h0 || h1 || (k != 4'hF && !l) || (k == 4'h0 && l);
    endfunction

    vec_t tv[8];
    logic [3:0] kset[8];

    initial begin
        int acc;
        int acc4[4];
        int lasts;
        int exp_fd;
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;

        tv[0] = '{32'hBEEF_1234, 4'hF, 1'b1, 2, 32'h1234_0000, 32'hBEEF_0000, 1'b0, 1'b1, 1, 0};
        tv[1] = '{32'hAAAA_5555, 4'hC, 1'b0, 1, 32'hAAAA_0000, 32'h0, 1'b0, 1'b0, 0, 1};
        tv[2] = '{32'h1234_5678, 4'h2, 1'b0, 0, 32'h0, 32'h0, 1'b0, 1'b0, 0, 1};
        tv[3] = '{32'hCAFE_F00D, 4'h3, 1'b1, 1, 32'hF00D_0000, 32'h0, 1'b1, 1'b0, 1, 0};
        tv[4] = '{32'h0001_0002, 4'hF, 1'b0, 2, 32'h0002_0000, 32'h0001_0000, 1'b0, 1'b0, 0, 0};
        tv[5] = '{32'h1111_2222, 4'h0, 1'b1, 0, 32'h0, 32'h0, 1'b0, 1'b0, 1, 1};
        tv[6] = '{32'h9999_8888, 4'h7, 1'b1, 1, 32'h8888_0000, 32'h0, 1'b1, 1'b0, 1, 1};
        tv[7] = '{32'h7777_6666, 4'hE, 1'b0, 1, 32'h7777_0000, 32'h0, 1'b0, 1'b0, 0, 1};
        kset  = '{4'hF, 4'hF, 4'hC, 4'h3, 4'h0, 4'h2, 4'h7, 4'hE};

        bus.s_axis_tdata  = '0;
        bus.s_axis_tkeep  = '0;
        bus.s_axis_tlast  = 1'b0;
        bus.s_axis_tvalid = 1'b0;

        // Reset values and release.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tready", 64'(bus.s_axis_tready), 64'd0);
        check("rst_valid", 64'(bus.m_word_valid), 64'd0);
        check("rst_last", 64'(bus.m_word_last), 64'd0);
        check("rst_data", 64'(bus.m_word_data), 64'd0);
        check("rst_fd", 64'(bus.frame_done), 64'd0);
        check("rst_err", 64'(bus.err_cnt), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("tready_after_rst", 64'(bus.s_axis_tready), 64'd1);
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Single-beat vector table.
        for (int i = 0; i < 8; i++) begin
            got.delete();
            fd_cnt = 0;
            send_beat(tv[i].d, tv[i].k, tv[i].l, acc);
            idle(6);
            if (ERR_EN) exp_err += tv[i].err;
            check($sformatf("v%0d_count", i), 64'(got.size()), 64'(tv[i].n));
            if (tv[i].n > 0 && got.size() > 0) begin
                check($sformatf("v%0d_w0", i), 64'(got[0].data), 64'(tv[i].w0));
                check($sformatf("v%0d_l0", i), 64'(got[0].last), 64'(tv[i].l0));
            end
            if (tv[i].n > 1 && got.size() > 1) begin
                check($sformatf("v%0d_w1", i), 64'(got[1].data), 64'(tv[i].w1));
                check($sformatf("v%0d_l1", i), 64'(got[1].last), 64'(tv[i].l1));
            end
            check($sformatf("v%0d_fd", i), 64'(fd_cnt), 64'(tv[i].fd));
            check($sformatf("v%0d_err", i), 64'(bus.err_cnt), 64'(exp_err));
        end

        // Full-beat throughput: one word per cycle, beats every other cycle.
        got.delete();
        fd_cnt = 0;
        for (int b = 0; b < 4; b++) begin
            d = {16'hB000 + 16'(b), 16'hA000 + 16'(b)};
            send_beat(d, 4'hF, (b == 3), acc4[b]);
        end
        idle(8);
        check("thr_count", 64'(got.size()), 64'd8);
        if (got.size() == 8) begin
            for (int j = 0; j < 8; j++) begin
                d = (j % 2 == 0) ? 32'hA000_0000 : 32'hB000_0000;
                d = d + (32'(j / 2) << 16);
                check($sformatf("thr_w%0d", j), 64'(got[j].data), 64'(d));
                check($sformatf("thr_l%0d", j), 64'(got[j].last), 64'(j == 7));
                if (j > 0)
                    check($sformatf("thr_gap%0d", j), 64'(got[j].c - got[j-1].c), 64'd1);
            end
        end
        for (int b = 1; b < 4; b++)
            check($sformatf("thr_acc%0d", b), 64'(acc4[b] - acc4[b-1]), 64'd2);
        check("thr_fd", 64'(fd_cnt), 64'd1);

        // Single-word beats: one beat accepted per cycle.
        got.delete();
        for (int b = 0; b < 4; b++)
            send_beat(32'hFFFF_0100 + 32'(b), 4'h3, 1'b0, acc4[b]);
        idle(6);
        check("sgl_count", 64'(got.size()), 64'd4);
        for (int b = 1; b < 4; b++)
            check($sformatf("sgl_acc%0d", b), 64'(acc4[b] - acc4[b-1]), 64'd1);

        // Empty tlast beat closing a frame body.
        got.delete();
        fd_cnt = 0;
        send_beat(32'h2222_1111, 4'hF, 1'b0, acc);
        send_beat(32'h4444_3333, 4'hF, 1'b0, acc);
        send_beat(32'h0, 4'h0, 1'b1, acc);
        idle(6);
        if (ERR_EN) exp_err += 1;
        lasts = 0;
        foreach (got[j]) lasts += int'(got[j].last);
        check("empty_count", 64'(got.size()), 64'd4);
        check("empty_no_last", 64'(lasts), 64'd0);
        check("empty_fd_cnt", 64'(fd_cnt), 64'd1);
        check("empty_fd_cyc", 64'(fd_cyc - acc), 64'd1);
        check("empty_err", 64'(bus.err_cnt), 64'(exp_err));

        // Random backpressure against a reference model.
        got.delete();
        exp_q.delete();
        fd_cnt = 0;
        exp_fd = 0;
        rand_ready = 1'b1;
        for (int b = 0; b < 100; b++) begin
            d = $urandom;
            k = kset[$urandom_range(0, 7)];
            l = ($urandom_range(0, 3) == 0);
            if (k[1:0] == 2'b11)
                exp_q.push_back('{WL'(d[15:0]) << (WL - 16),
                                  l && k[3:2] != 2'b11, 0});
            if (k[3:2] == 2'b11)
                exp_q.push_back('{WL'(d[31:16]) << (WL - 16), l, 0});
            if (l) exp_fd++;
            if (ERR_EN && is_bad(k, l)) exp_err++;
            send_beat(d, k, l, acc);
        end
        rand_ready = 1'b0;
        idle(20);
        check("rnd_count", 64'(got.size()), 64'(exp_q.size()));
        for (int j = 0; j < exp_q.size() && j < got.size(); j++) begin
            check($sformatf("rnd_w%0d", j), 64'(got[j].data), 64'(exp_q[j].data));
            check($sformatf("rnd_l%0d", j), 64'(got[j].last), 64'(exp_q[j].last));
        end
        check("rnd_fd", 64'(fd_cnt), 64'(exp_fd));
        check("rnd_err", 64'(bus.err_cnt), 64'(exp_err));

        // Reset while word1 is still pending behind a stalled output.
        hold_low = 1'b1;
        idle(2);
        send_beat(32'h5678_4321, 4'hF, 1'b1, acc);
        idle(3);
        check("stall_valid", 64'(bus.m_word_valid), 64'd1);
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 64'(bus.m_word_valid), 64'd0);
        check("mid_rst_data", 64'(bus.m_word_data), 64'd0);
        check("mid_rst_last", 64'(bus.m_word_last), 64'd0);
        check("mid_rst_tready", 64'(bus.s_axis_tready), 64'd0);
        check("mid_rst_fd", 64'(bus.frame_done), 64'd0);
        check("mid_rst_err", 64'(bus.err_cnt), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        hold_low = 1'b0;
        got.delete();
        fd_cnt = 0;
        mon_en = 1'b1;
        idle(2);
        send_beat(32'h0BAD_F00D, 4'hF, 1'b1, acc);
        idle(6);
        check("post_rst_count", 64'(got.size()), 64'd2);
        if (got.size() == 2) begin
            check("post_rst_w0", 64'(got[0].data), 64'h0000_0000_F00D_0000);
            check("post_rst_w1", 64'(got[1].data), 64'h0000_0000_0BAD_0000);
            check("post_rst_l1", 64'(got[1].last), 64'd1);
        end
        check("post_rst_fd", 64'(fd_cnt), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
